// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter in front of a single-cycle shared 32-bit data memory
// Ports: clk, reset (synchronous, active-low)
//        m0_*/m1_*   : req/addr/wdata/byteen in; gnt (combinational), rvalid/rdata/err (registered) out
//        mem_addr/mem_wdata/mem_byteen : granted transfer to memory; mem_rdata : memory read data
module dm_arbiter #(
    parameter int MODE        = 0,
    parameter int MAX_WAIT    = 4,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata
);
    logic        last_gnt;
    logic [3:0]  wait1;
    logic        sel1;
    logic        any;
    logic        oor;
    logic [31:0] g_addr;
    logic [3:0]  g_byteen;
    logic        rvalid0;
    logic        rvalid1;

    // sel1 picks port 1 as the candidate; single requesters win outright
    always_comb begin
        sel1       = (m0_req && m1_req) ? (MODE == 0 ? !last_gnt : wait1 == 4'(MAX_WAIT)) : m1_req;
        m0_gnt     = reset && m0_req && !sel1;
        m1_gnt     = reset && m1_req && sel1;
        any        = m0_gnt || m1_gnt;
        g_addr     = sel1 ? m1_addr : m0_addr;
        g_byteen   = sel1 ? m1_byteen : m0_byteen;
        oor        = {2'b00, g_addr[31:2]} >= 32'(DEPTH_WORDS);
        mem_addr   = any ? {g_addr[31:2], 2'b00} : 32'h0;
        mem_wdata  = any ? (sel1 ? m1_wdata : m0_wdata) : 32'h0;
        mem_byteen = (any && !oor) ? g_byteen : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_gnt <= 1'b1;
            wait1    <= 4'd0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            m0_rdata <= 32'h0;
            m1_rdata <= 32'h0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
        end else begin
            if (any)
                last_gnt <= m1_gnt;
            wait1    <= (m1_req && !m1_gnt) ? (wait1 == 4'(MAX_WAIT) ? wait1 : wait1 + 4'd1) : 4'd0;
            rvalid0  <= m0_gnt;
            rvalid1  <= m1_gnt;
            m0_err   <= m0_gnt && oor;
            m1_err   <= m1_gnt && oor;
            m0_rdata <= (m0_gnt && !oor && g_byteen == 4'h0) ? mem_rdata : 32'h0;
            m1_rdata <= (m1_gnt && !oor && g_byteen == 4'h0) ? mem_rdata : 32'h0;
        end
    end

    // a response registered just before reset asserts must never be presented
    assign m0_rvalid = rvalid0 && reset;
    assign m1_rvalid = rvalid1 && reset;
endmodule
